// File: rtl/out_nu_blk_core.sv
// Output-layer spiking block: N leaky integrate-and-fire neurons fed serially
// from an M-bit input spike frame, with threshold, refractory and leak rules.
module out_nu_blk_core #(
  parameter int M    = 10,
  parameter int N    = 3,
  parameter int W    = 8,
  parameter int D    = 1,
  parameter int TH   = 90,
  parameter int REF  = 30,
  parameter int PRES = 10,
  parameter int PMIN = -10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_op_nub,
  input  logic         TU_incre,
  input  logic [M-1:0] spike_ip_nub,
  output logic         valid_op_nub,
  output logic [N-1:0] spike_op_nub
);

  localparam int RW = $clog2(REF + 1);
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  localparam logic signed [15:0] PRES16 = 16'(PRES);
  localparam logic signed [15:0] PMIN16 = 16'(PMIN);
  localparam logic signed [15:0] TH16   = 16'(TH);
  localparam logic signed [15:0] D16    = 16'(D);
  localparam logic signed [16:0] SMAX   = 17'sd32767;
  localparam logic signed [16:0] SMIN   = -17'sd32768;

  typedef enum logic [1:0] {IDLE, ACC, FIRE} state_t;

  state_t                state_q, state_d;
  logic [M-1:0]          frame_q, frame_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  tu_pend_q, tu_pend_d;
  logic                  valid_q, valid_d;
  logic [N-1:0]          spike_q, spike_d;
  logic signed [15:0]    pot_q [N];
  logic signed [15:0]    pot_d [N];
  logic [RW-1:0]         refr_q [N];
  logic [RW-1:0]         refr_d [N];
  logic signed [W-1:0]   w_q [N][M];

  // Saturating 16-bit add followed by the lower potential clamp.
  function automatic logic signed [15:0] acc_step(input logic signed [15:0] p,
                                                  input logic signed [W-1:0] w);
    logic signed [16:0] s;
    logic signed [15:0] r;
    s = $signed({p[15], p}) + $signed({{(17-W){w[W-1]}}, w});
    if (s > SMAX)      r = 16'sh7fff;
    else if (s < SMIN) r = 16'sh8000;
    else               r = s[15:0];
    if (r < PMIN16) r = PMIN16;
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    tu_pend_d = tu_pend_q;
    valid_d   = 1'b0;
    spike_d   = spike_q;
    pot_d     = pot_q;
    refr_d    = refr_q;

    case (state_q)
      IDLE: begin
        // Time unit is applied before a coincident frame so the frame sees leaked potentials.
        if (TU_incre || tu_pend_q) begin
          tu_pend_d = 1'b0;
          for (int n = 0; n < N; n++) begin
            if (refr_q[n] != '0) begin
              refr_d[n] = refr_q[n] - 1'b1;
            end else if (pot_q[n] > PRES16) begin
              pot_d[n] = (pot_q[n] - D16 < PRES16) ? PRES16 : pot_q[n] - D16;
            end else if (pot_q[n] < PRES16) begin
              pot_d[n] = (pot_q[n] + D16 > PRES16) ? PRES16 : pot_q[n] + D16;
            end
          end
        end
        if (start_op_nub) begin
          frame_d = spike_ip_nub;
          idx_d   = '0;
          state_d = ACC;
        end
      end

      ACC: begin
        tu_pend_d = tu_pend_q | TU_incre;
        for (int n = 0; n < N; n++) begin
          if (refr_q[n] == '0 && frame_q[idx_q]) begin
            pot_d[n] = acc_step(pot_q[n], w_q[n][idx_q]);
          end
        end
        if (idx_q == IW'(M - 1)) state_d = FIRE;
        else                     idx_d   = idx_q + 1'b1;
      end

      FIRE: begin
        tu_pend_d = tu_pend_q | TU_incre;
        valid_d   = 1'b1;
        for (int n = 0; n < N; n++) begin
          if (refr_q[n] == '0 && pot_q[n] >= TH16) begin
            spike_d[n] = 1'b1;
            pot_d[n]   = PRES16;
            refr_d[n]  = RW'(REF);
          end else begin
            spike_d[n] = 1'b0;
          end
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Weights are loaded only by reset and otherwise hold their value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      tu_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      spike_q   <= '0;
      for (int n = 0; n < N; n++) begin
        pot_q[n]  <= PRES16;
        refr_q[n] <= '0;
        for (int m = 0; m < M; m++) begin
          w_q[n][m] <= W'(8 * ((m + n) % 4) - 8);
        end
      end
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      tu_pend_q <= tu_pend_d;
      valid_q   <= valid_d;
      spike_q   <= spike_d;
      pot_q     <= pot_d;
      refr_q    <= refr_d;
    end
  end

  assign valid_op_nub = valid_q;
  assign spike_op_nub = spike_q;

endmodule

// File: tb/tb_out_nu_blk_core.sv
// Directed bench for out_nu_blk_core: latency, integration/leak, clamp,
// refractory, deferred time-unit and asynchronous reset behaviour.
module tb_out_nu_blk_core;

  localparam int M = 10;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_op_nub = 1'b0;
  logic         TU_incre = 1'b0;
  logic [M-1:0] spike_ip_nub = '0;
  logic         valid_op_nub;
  logic [N-1:0] spike_op_nub;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  out_nu_blk_core dut (
    .clk          (clk),
    .rst          (rst),
    .start_op_nub (start_op_nub),
    .TU_incre     (TU_incre),
    .spike_ip_nub (spike_ip_nub),
    .valid_op_nub (valid_op_nub),
    .spike_op_nub (spike_op_nub)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkPots(input string tag, input int p0, input int p1, input int p2);
    checkOutput({tag, "_pot0"}, $signed(dut.pot_q[0]), p0);
    checkOutput({tag, "_pot1"}, $signed(dut.pot_q[1]), p1);
    checkOutput({tag, "_pot2"}, $signed(dut.pot_q[2]), p2);
  endtask

  // Count cycles until valid, bounded so a stuck design still reaches the summary.
  task automatic waitValid(output int lat);
    lat = 0;
    while (valid_op_nub !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called at posedge+1; returns in the valid cycle with lat = edges after the start edge.
  task automatic applyStimulus(input logic [M-1:0] frame, output int lat);
    spike_ip_nub = frame;
    start_op_nub = 1'b1;
    @(posedge clk); #1;
    start_op_nub = 1'b0;
    waitValid(lat);
  endtask

  task automatic pulseTu();
    TU_incre = 1'b1;
    @(posedge clk); #1;
    TU_incre = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int lat;
    logic [N-1:0] exp_spike [4];
    exp_spike = '{3'b000, 3'b100, 3'b010, 3'b001};

    // Reset state
    #2 rst = 1'b0;
    #2;
    checkOutput("rst_valid", valid_op_nub, 0);
    checkOutput("rst_spike", spike_op_nub, 0);
    checkPots("rst", 10, 10, 10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Latency with an empty frame
    applyStimulus('0, lat);
    checkOutput("lat_cycles", lat, 11);
    checkOutput("lat_spike", spike_op_nub, 0);
    @(posedge clk); #1;
    checkOutput("lat_valid_one_cycle", valid_op_nub, 0);
    checkPots("lat", 10, 10, 10);

    // Integration and leak over four frames
    for (int f = 0; f < 4; f++) begin
      applyStimulus('1, lat);
      checkOutput($sformatf("int_lat_f%0d", f + 1), lat, 11);
      checkOutput($sformatf("int_spike_f%0d", f + 1), spike_op_nub, exp_spike[f]);
      if (f == 0) checkPots("int_f1", 34, 50, 66);
      pulseTu();
      if (f == 0) checkPots("int_f1_tu", 33, 49, 65);
    end
    checkPots("int_end", 10, 10, 10);

    // Asynchronous reset in the middle of a frame
    spike_ip_nub = '1;
    start_op_nub = 1'b1;
    @(posedge clk); #1;
    start_op_nub = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("midrst_valid", valid_op_nub, 0);
    checkOutput("midrst_spike", spike_op_nub, 0);
    checkPots("midrst", 10, 10, 10);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus('1, lat);
    checkOutput("postrst_lat", lat, 11);
    checkOutput("postrst_spike", spike_op_nub, 0);
    checkPots("postrst", 34, 50, 66);

    // Lower clamp
    doReset();
    applyStimulus(10'b0100010001, lat);
    checkOutput("pmin_lat", lat, 11);
    checkOutput("pmin_spike", spike_op_nub, 0);
    checkPots("pmin", -10, 10, 34);

    // Deferred time unit plus an ignored start during ACC
    doReset();
    spike_ip_nub = '1;
    start_op_nub = 1'b1;
    @(posedge clk); #1;
    start_op_nub = 1'b0;
    @(posedge clk); #1;
    TU_incre = 1'b1;
    @(posedge clk); #1;
    TU_incre = 1'b0;
    start_op_nub = 1'b1;
    spike_ip_nub = '0;
    @(posedge clk); #1;
    start_op_nub = 1'b0;
    TU_incre = 1'b1;
    @(posedge clk); #1;
    TU_incre = 1'b0;
    waitValid(lat);
    checkOutput("dtu_valid", valid_op_nub, 1);
    checkOutput("dtu_spike", spike_op_nub, 0);
    checkPots("dtu_at_valid", 34, 50, 66);
    @(posedge clk); #1;
    checkPots("dtu_applied", 33, 49, 65);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("dtu_no_extra_valid", valid_op_nub, 0);
    checkPots("dtu_once", 33, 49, 65);

    // Refractory window of neuron 2
    doReset();
    applyStimulus('1, lat);
    pulseTu();
    applyStimulus('1, lat);
    checkOutput("refr_fire_spike", spike_op_nub, 3'b100);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus('1, lat);
      checkOutput($sformatf("refr_bit2_f%0d", k), spike_op_nub[2], 0);
      checkOutput($sformatf("refr_pot2_f%0d", k), $signed(dut.pot_q[2]), 10);
      pulseTu();
    end
    applyStimulus('1, lat);
    checkOutput("refr_f31_lat", lat, 11);
    checkOutput("refr_f31_bit2", spike_op_nub[2], 0);
    checkOutput("refr_f31_pot2", $signed(dut.pot_q[2]), 66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
